// File: rtl/node_id_pkg.sv
// Shared types for the node-name to node-index allocator: name width, LUT entry
// layout and controller states.
package node_id_pkg;

    // Three letters of five bits each.
    localparam int unsigned NODE_STR_WIDTH = 15;

    // Widest index an entry can carry; the live index width is a parameter of the block.
    localparam int unsigned LUT_IDX_MAX_WIDTH = 15;

    // LUT entry: the valid flag sits above the index in the stored word.
    typedef struct packed {
        logic                         valid;
        logic [LUT_IDX_MAX_WIDTH-1:0] idx;
    } lut_entry_t;

    typedef enum logic [2:0] {
        StClear,
        StIdle,
        StLookup,
        StResolve,
        StEmit
    } alloc_state_e;

endpackage

// File: rtl/node_id_allocator.sv
// Maps 15-bit node names of incoming edges to dense node indices using an external
// dual-port LUT (1-cycle read latency, read-before-write). One edge is in flight at
// a time: IDLE -> LOOKUP -> RESOLVE -> EMIT.
// Build option NODE_ID_ALLOC_CLEAR_EN: when defined, reset first sweeps the whole LUT
// to zero (CLEAR state); when undefined, the LUT is assumed zero-initialised.
module node_id_allocator #(
    parameter int NODE_STR_WIDTH = node_id_pkg::NODE_STR_WIDTH,
    parameter int MAX_NODES      = 1024,
    parameter int NODE_IDX_WIDTH = $clog2(MAX_NODES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NODE_STR_WIDTH-1:0] in_src_str,
    input  logic [NODE_STR_WIDTH-1:0] in_dst_str,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NODE_IDX_WIDTH-1:0] out_src_idx,
    output logic [NODE_IDX_WIDTH-1:0] out_dst_idx,
    output logic [NODE_IDX_WIDTH:0]   node_count,
    output logic                      overflow,
    output logic                      init_done,
    output logic                      node_lut_src_wr_en,
    output logic                      node_lut_dst_wr_en,
    output logic [NODE_STR_WIDTH-1:0] src_node_str,
    output logic [NODE_STR_WIDTH-1:0] dst_node_str,
    output logic [NODE_IDX_WIDTH:0]   node_lut_src_wr_data,
    output logic [NODE_IDX_WIDTH:0]   node_lut_dst_wr_data,
    input  logic [NODE_IDX_WIDTH:0]   node_lut_src_rd_data,
    input  logic [NODE_IDX_WIDTH:0]   node_lut_dst_rd_data
);
    import node_id_pkg::*;

    localparam logic [NODE_IDX_WIDTH:0]   CNT_LIMIT = (NODE_IDX_WIDTH + 1)'(MAX_NODES);
    localparam logic [NODE_IDX_WIDTH:0]   CNT_ONE   = (NODE_IDX_WIDTH + 1)'(1);
    localparam logic [NODE_IDX_WIDTH-1:0] IDX_SAT   = NODE_IDX_WIDTH'(MAX_NODES - 1);

`ifdef NODE_ID_ALLOC_CLEAR_EN
    localparam int                   CLR_WIDTH   = NODE_STR_WIDTH - 1;
    localparam logic [CLR_WIDTH-1:0] CLR_ONE     = CLR_WIDTH'(1);
    localparam alloc_state_e         RESET_STATE = StClear;
    logic [CLR_WIDTH-1:0] clr_cnt_q;
`else
    localparam alloc_state_e         RESET_STATE = StIdle;
`endif

    alloc_state_e              state_q;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [NODE_IDX_WIDTH-1:0] out_src_q;
    logic [NODE_IDX_WIDTH-1:0] out_dst_q;
    logic [NODE_IDX_WIDTH:0]   node_count_q;
    logic                      overflow_q;
    logic                      init_done_q;
    logic                      wr_a_q;
    logic                      wr_b_q;
    logic [NODE_STR_WIDTH-1:0] addr_a_q;
    logic [NODE_STR_WIDTH-1:0] addr_b_q;
    logic [NODE_IDX_WIDTH:0]   wdata_a_q;
    logic [NODE_IDX_WIDTH:0]   wdata_b_q;

    lut_entry_t                src_ent;
    lut_entry_t                dst_ent;
    logic                      same_str;
    logic [NODE_IDX_WIDTH-1:0] res_src_idx;
    logic [NODE_IDX_WIDTH-1:0] res_dst_idx;
    logic [NODE_IDX_WIDTH:0]   res_count;
    logic                      res_wr_a;
    logic                      res_wr_b;
    logic                      res_ovf;
    logic                      unused_ent_idx;

    // The latched names double as the LUT addresses, so equality is checked on them.
    assign same_str = (addr_a_q == addr_b_q);

    // Resolve both sides from the LUT read data; src allocates before dst.
    always_comb begin
        src_ent.valid = node_lut_src_rd_data[NODE_IDX_WIDTH];
        src_ent.idx   = LUT_IDX_MAX_WIDTH'(node_lut_src_rd_data[NODE_IDX_WIDTH-1:0]);
        dst_ent.valid = node_lut_dst_rd_data[NODE_IDX_WIDTH];
        dst_ent.idx   = LUT_IDX_MAX_WIDTH'(node_lut_dst_rd_data[NODE_IDX_WIDTH-1:0]);
        res_count     = node_count_q;
        res_wr_a      = 1'b0;
        res_wr_b      = 1'b0;
        res_ovf       = 1'b0;
        res_src_idx   = src_ent.idx[NODE_IDX_WIDTH-1:0];
        res_dst_idx   = dst_ent.idx[NODE_IDX_WIDTH-1:0];
        if (!src_ent.valid) begin
            if (res_count < CNT_LIMIT) begin
                res_src_idx = res_count[NODE_IDX_WIDTH-1:0];
                res_wr_a    = 1'b1;
                res_count   = res_count + CNT_ONE;
            end else begin
                res_src_idx = IDX_SAT;
                res_ovf     = 1'b1;
            end
        end
        // A self-loop uses one index and writes only port A to avoid a same-address
        // dual-port write.
        if (same_str) begin
            res_dst_idx = res_src_idx;
        end else if (!dst_ent.valid) begin
            if (res_count < CNT_LIMIT) begin
                res_dst_idx = res_count[NODE_IDX_WIDTH-1:0];
                res_wr_b    = 1'b1;
                res_count   = res_count + CNT_ONE;
            end else begin
                res_dst_idx = IDX_SAT;
                res_ovf     = 1'b1;
            end
        end
    end

    // Index bits above the configured width are always zero.
    assign unused_ent_idx = ^{src_ent.idx, dst_ent.idx};

    // Controller FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_STATE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_src_q    <= '0;
            out_dst_q    <= '0;
            node_count_q <= '0;
            overflow_q   <= 1'b0;
            init_done_q  <= 1'b0;
            wr_a_q       <= 1'b0;
            wr_b_q       <= 1'b0;
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            wdata_a_q    <= '0;
            wdata_b_q    <= '0;
`ifdef NODE_ID_ALLOC_CLEAR_EN
            clr_cnt_q    <= '0;
`endif
        end else begin
            wr_a_q <= 1'b0;
            wr_b_q <= 1'b0;
            unique case (state_q)
`ifdef NODE_ID_ALLOC_CLEAR_EN
                StClear: begin
                    // Port A sweeps the lower half of the LUT, port B the upper half.
                    addr_a_q  <= {1'b0, clr_cnt_q};
                    addr_b_q  <= {1'b1, clr_cnt_q};
                    wdata_a_q <= '0;
                    wdata_b_q <= '0;
                    wr_a_q    <= 1'b1;
                    wr_b_q    <= 1'b1;
                    clr_cnt_q <= clr_cnt_q + CLR_ONE;
                    if (&clr_cnt_q) begin
                        state_q     <= StIdle;
                        init_done_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end
                end
`endif
                StIdle: begin
                    if (!init_done_q) begin
                        // First cycle after reset when there is no clear sweep.
                        init_done_q <= 1'b1;
                        in_ready_q  <= 1'b1;
                    end else if (in_valid && in_ready_q) begin
                        addr_a_q   <= in_src_str;
                        addr_b_q   <= in_dst_str;
                        in_ready_q <= 1'b0;
                        state_q    <= StLookup;
                    end
                end
                StLookup: begin
                    state_q <= StResolve;
                end
                StResolve: begin
                    out_src_q    <= res_src_idx;
                    out_dst_q    <= res_dst_idx;
                    out_valid_q  <= 1'b1;
                    node_count_q <= res_count;
                    overflow_q   <= overflow_q | res_ovf;
                    wr_a_q       <= res_wr_a;
                    wr_b_q       <= res_wr_b;
                    wdata_a_q    <= {1'b1, res_src_idx};
                    wdata_b_q    <= {1'b1, res_dst_idx};
                    state_q      <= StEmit;
                end
                StEmit: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= RESET_STATE;
                end
            endcase
        end
    end

    assign in_ready             = in_ready_q;
    assign out_valid            = out_valid_q;
    assign out_src_idx          = out_src_q;
    assign out_dst_idx          = out_dst_q;
    assign node_count           = node_count_q;
    assign overflow             = overflow_q;
    assign init_done            = init_done_q;
    assign node_lut_src_wr_en   = wr_a_q;
    assign node_lut_dst_wr_en   = wr_b_q;
    assign src_node_str         = addr_a_q;
    assign dst_node_str         = addr_b_q;
    assign node_lut_src_wr_data = wdata_a_q;
    assign node_lut_dst_wr_data = wdata_b_q;

endmodule

// File: tb/tb_node_id_allocator.sv
// Bench for node_id_allocator: two instances (MAX_NODES=1024 and MAX_NODES=4), each
// with a behavioural 1-cycle-latency read-before-write dual-port LUT.
module tb_node_id_allocator;
    localparam int SW  = 15;
    localparam int IW0 = 10;
    localparam int IW1 = 2;
`ifdef NODE_ID_ALLOC_CLEAR_EN
    localparam int CLR_CYCLES = 16384;
    localparam bit FILL_ONES  = 1'b1;
`else
    localparam int CLR_CYCLES = 1;
    localparam bit FILL_ONES  = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic fill_req = 1'b1;
    always #5 clk = ~clk;

    logic           in_valid0 = 1'b0, out_ready0 = 1'b0;
    logic [SW-1:0]  in_src0 = '0, in_dst0 = '0;
    logic           in_ready0, out_valid0, overflow0, init_done0, wa_en0, wb_en0;
    logic [SW-1:0]  addr_a0, addr_b0;
    logic [IW0-1:0] out_src0, out_dst0;
    logic [IW0:0]   count0, wd_a0, wd_b0, rd_a0, rd_b0;

    logic           in_valid1 = 1'b0, out_ready1 = 1'b0;
    logic [SW-1:0]  in_src1 = '0, in_dst1 = '0;
    logic           in_ready1, out_valid1, overflow1, init_done1, wa_en1, wb_en1;
    logic [SW-1:0]  addr_a1, addr_b1;
    logic [IW1-1:0] out_src1, out_dst1;
    logic [IW1:0]   count1, wd_a1, wd_b1, rd_a1, rd_b1;

    node_id_allocator dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_src_str(in_src0), .in_dst_str(in_dst0), .out_valid(out_valid0),
        .out_ready(out_ready0), .out_src_idx(out_src0), .out_dst_idx(out_dst0),
        .node_count(count0), .overflow(overflow0), .init_done(init_done0),
        .node_lut_src_wr_en(wa_en0), .node_lut_dst_wr_en(wb_en0),
        .src_node_str(addr_a0), .dst_node_str(addr_b0),
        .node_lut_src_wr_data(wd_a0), .node_lut_dst_wr_data(wd_b0),
        .node_lut_src_rd_data(rd_a0), .node_lut_dst_rd_data(rd_b0)
    );

    node_id_allocator #(.MAX_NODES(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_src_str(in_src1), .in_dst_str(in_dst1), .out_valid(out_valid1),
        .out_ready(out_ready1), .out_src_idx(out_src1), .out_dst_idx(out_dst1),
        .node_count(count1), .overflow(overflow1), .init_done(init_done1),
        .node_lut_src_wr_en(wa_en1), .node_lut_dst_wr_en(wb_en1),
        .src_node_str(addr_a1), .dst_node_str(addr_b1),
        .node_lut_src_wr_data(wd_a1), .node_lut_dst_wr_data(wd_b1),
        .node_lut_src_rd_data(rd_a1), .node_lut_dst_rd_data(rd_b1)
    );

    // Behavioural LUTs; fill_req preloads them (garbage when the clear sweep exists).
    logic [IW0:0] ram0 [1<<SW];
    logic [IW1:0] ram1 [1<<SW];
    int wcnt_a0 = 0, wcnt_b0 = 0, wcnt_a1 = 0, wcnt_b1 = 0;

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < (1 << SW); i++) begin
                ram0[i] <= {(IW0 + 1){FILL_ONES}};
                ram1[i] <= {(IW1 + 1){FILL_ONES}};
            end
        end else begin
            rd_a0 <= ram0[addr_a0];
            rd_b0 <= ram0[addr_b0];
            rd_a1 <= ram1[addr_a1];
            rd_b1 <= ram1[addr_b1];
            if (wa_en0) begin ram0[addr_a0] <= wd_a0; wcnt_a0 <= wcnt_a0 + 1; end
            if (wb_en0) begin ram0[addr_b0] <= wd_b0; wcnt_b0 <= wcnt_b0 + 1; end
            if (wa_en1) begin ram1[addr_a1] <= wd_a1; wcnt_a1 <= wcnt_a1 + 1; end
            if (wb_en1) begin ram1[addr_b1] <= wd_b1; wcnt_b1 <= wcnt_b1 + 1; end
        end
    end

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] enc(input string s);
        logic [SW-1:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) r = {r[SW-6:0], 5'(s[i] - 8'd96)};
        return r;
    endfunction

    function automatic int rdy(input int sel);  return sel != 0 ? int'(in_ready1)  : int'(in_ready0);  endfunction
    function automatic int vld(input int sel);  return sel != 0 ? int'(out_valid1) : int'(out_valid0); endfunction
    function automatic int osrc(input int sel); return sel != 0 ? int'(out_src1)   : int'(out_src0);   endfunction
    function automatic int odst(input int sel); return sel != 0 ? int'(out_dst1)   : int'(out_dst0);   endfunction
    function automatic int cnt(input int sel);  return sel != 0 ? int'(count1)     : int'(count0);     endfunction
    function automatic int ovf(input int sel);  return sel != 0 ? int'(overflow1)  : int'(overflow0);  endfunction
    function automatic int wen(input int sel);
        return sel != 0 ? int'(wa_en1 | wb_en1) : int'(wa_en0 | wb_en0);
    endfunction
    function automatic int wa(input int sel); return sel != 0 ? wcnt_a1 : wcnt_a0; endfunction
    function automatic int wb(input int sel); return sel != 0 ? wcnt_b1 : wcnt_b0; endfunction

    task automatic drive(input int sel, input logic v, input logic [SW-1:0] s, input logic [SW-1:0] d);
        if (sel != 0) begin in_valid1 = v; in_src1 = s; in_dst1 = d; end
        else begin in_valid0 = v; in_src0 = s; in_dst0 = d; end
    endtask

    task automatic set_ordy(input int sel, input logic v);
        if (sel != 0) out_ready1 = v;
        else out_ready0 = v;
    endtask

    // Offer one edge, check latency and stall behaviour, then consume the result.
    task automatic run_edge(input int sel, input logic [SW-1:0] s, input logic [SW-1:0] d,
                            input int hold, input string tag, output int rs, output int rd);
        int t;
        int lat;
        int bad;
        t = 0;
        @(negedge clk);
        while (rdy(sel) != 1 && t < 40) begin @(negedge clk); t++; end
        chk({tag, "_in_ready"}, rdy(sel), 1);
        drive(sel, 1'b1, s, d);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, '0, '0);
        lat = 0;
        do begin @(negedge clk); lat++; end while (vld(sel) != 1 && lat < 10);
        chk({tag, "_latency"}, lat, 3);
        rs = osrc(sel);
        rd = odst(sel);
        bad = 0;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (osrc(sel) != rs || odst(sel) != rd || vld(sel) != 1 || rdy(sel) != 0 ||
                wen(sel) != 0) bad++;
        end
        if (hold > 0) chk({tag, "_stall_stable"}, bad, 0);
        set_ordy(sel, 1'b1);
        @(posedge clk);
        #1;
        set_ordy(sel, 1'b0);
        chk({tag, "_out_valid_drop"}, vld(sel), 0);
    endtask

    task automatic wait_init(input string tag);
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (init_done0 !== 1'b1 && n < 20000);
        chk({tag, "_cycles"}, n, CLR_CYCLES);
        chk({tag, "_dut1"}, int'(init_done1), 1);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int            sel;
        logic [SW-1:0] src;
        logic [SW-1:0] dst;
        int            hold;
        int            es;
        int            ed;
        int            ecnt;
        int            eovf;
        int            ewa;
        int            ewb;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int gs, gd, sa, sb, nz;
        string tag;
        //            sel src          dst          hold src dst cnt ovf wrA wrB
        vecs[0] = '{0, enc("aaa"), enc("bbb"), 0, 0, 1, 2, 0, 1, 1};
        vecs[1] = '{0, enc("bbb"), enc("ccc"), 5, 1, 2, 3, 0, 0, 1};
        vecs[2] = '{1, enc("aaa"), enc("bbb"), 0, 0, 1, 2, 0, 1, 1};
        vecs[3] = '{1, enc("ccc"), enc("ddd"), 0, 2, 3, 4, 0, 1, 1};
        vecs[4] = '{1, enc("eee"), enc("fff"), 0, 3, 3, 4, 1, 0, 0};

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready0), 0);
        chk("rst_out_valid", int'(out_valid0), 0);
        chk("rst_node_count", int'(count0), 0);
        chk("rst_overflow", int'(overflow0), 0);
        chk("rst_init_done", int'(init_done0), 0);
        chk("rst_wr_en", int'(wa_en0 | wb_en0), 0);
        chk("rst_addr_idx", int'(addr_a0 | addr_b0) + int'(out_src0 | out_dst0), 0);
        @(negedge clk);
        fill_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("init");

        nz = 0;
        for (int i = 0; i < (1 << SW); i++) if (ram0[i] != 0 || ram1[i] != 0) nz++;
        chk("lut_all_zero", nz, 0);

        for (int k = 0; k < 5; k++) begin
            tag = $sformatf("v%0d", k);
            sa = wa(vecs[k].sel);
            sb = wb(vecs[k].sel);
            run_edge(vecs[k].sel, vecs[k].src, vecs[k].dst, vecs[k].hold, tag, gs, gd);
            chk({tag, "_src_idx"}, gs, vecs[k].es);
            chk({tag, "_dst_idx"}, gd, vecs[k].ed);
            chk({tag, "_node_count"}, cnt(vecs[k].sel), vecs[k].ecnt);
            chk({tag, "_overflow"}, ovf(vecs[k].sel), vecs[k].eovf);
            chk({tag, "_writes_a"}, wa(vecs[k].sel) - sa, vecs[k].ewa);
            chk({tag, "_writes_b"}, wb(vecs[k].sel) - sb, vecs[k].ewb);
        end

        // Reset asserted while dut0 sits in RESOLVE: the edge must leave no trace.
        @(negedge clk);
        chk("mid_in_ready", int'(in_ready0), 1);
        drive(0, 1'b1, enc("qqq"), enc("rrr"));
        @(posedge clk);
        #1;
        drive(0, 1'b0, '0, '0);
        @(posedge clk);
        #1;
        sa = wcnt_a0;
        sb = wcnt_b0;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", int'(wa_en0 | wb_en0), 0);
        chk("mid_rst_node_count", int'(count0), 0);
        chk("mid_rst_out_valid", int'(out_valid0), 0);
        chk("mid_rst_overflow1", int'(overflow1), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_no_write", (wcnt_a0 - sa) + (wcnt_b0 - sb), 0);
        chk("mid_rst_lut_src", int'(ram0[enc("qqq")]), 0);
        chk("mid_rst_lut_dst", int'(ram0[enc("rrr")]), 0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_init("reinit");

        run_edge(0, enc("aaa"), enc("bbb"), 1, "post_rst", gs, gd);
        chk("post_rst_src_idx", gs, 0);
        chk("post_rst_dst_idx", gd, 1);

        // Self-loop on an empty allocator: one index, port A only.
        sa = wcnt_a1;
        sb = wcnt_b1;
        run_edge(1, enc("xyz"), enc("xyz"), 0, "self", gs, gd);
        chk("self_src_idx", gs, 0);
        chk("self_dst_idx", gd, 0);
        chk("self_node_count", int'(count1), 1);
        chk("self_overflow", int'(overflow1), 0);
        chk("self_writes_a", wcnt_a1 - sa, 1);
        chk("self_writes_b", wcnt_b1 - sb, 0);
        chk("self_lut_entry", int'(ram1[enc("xyz")]), 4);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
